// File: rtl/multdiv_result_reader_if.sv
// Handshake bundle between the multdiv datapath, the result buffer and writeback.
// The master side drives results in and accepts them out; the slave side is the buffer.
interface multdiv_result_reader_if #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic             in_is_div;
    logic             in_div_zero;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_exception;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, in_data, in_is_div, in_div_zero, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_exception, out_tag, count
    );

    modport slave (
        input  in_valid, in_data, in_is_div, in_div_zero, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_exception, out_tag, count
    );
endinterface

// File: rtl/multdiv_result_reader.sv
// Small FIFO reducing 64-bit multdiv results to a 32-bit writeback value plus exception flag.
// Optional same-cycle empty-queue bypass: define MULTDIV_RESULT_BYPASS_EN.
module multdiv_result_reader #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    multdiv_result_reader_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Bit 32 is the exception flag, bits 31:0 the writeback value.
    function automatic logic [32:0] reduce_result(
        input logic [63:0] raw,
        input logic        is_div,
        input logic        div_zero
    );
        logic [32:0] r;
        if (is_div) begin
            if (div_zero) begin
                r = {1'b1, 32'h0000_0000};
            end else begin
                r = {1'b0, raw[31:0]};
            end
        end else begin
            r = {~((raw[63:31] == {33{1'b0}}) || (raw[63:31] == {33{1'b1}})), raw[31:0]};
        end
        return r;
    endfunction

    logic [31:0]      data_mem_r [DEPTH];
    logic             exc_mem_r  [DEPTH];
    logic [TAG_W-1:0] tag_mem_r  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic [32:0]      in_reduced_s;
    logic             not_empty_s;
    logic             in_ready_s;
    logic             push_s;
    logic             write_s;
    logic             read_s;
    logic             out_valid_s;
    logic [32:0]      out_word_s;
    logic [TAG_W-1:0] out_tag_s;

    assign in_reduced_s = reduce_result(bus.in_data, bus.in_is_div, bus.in_div_zero);
    assign not_empty_s  = (count_r != {CNT_W{1'b0}});
    assign in_ready_s   = (count_r < CNT_W'(DEPTH));
    assign push_s       = bus.in_valid & in_ready_s;
    assign read_s       = not_empty_s & bus.out_ready;

`ifdef MULTDIV_RESULT_BYPASS_EN
    logic bypass_s;
    // An empty queue forwards the incoming result; it is stored only if writeback stalls.
    assign bypass_s    = ~not_empty_s & bus.in_valid;
    assign out_valid_s = not_empty_s | bypass_s;
    assign write_s     = push_s & ~(bypass_s & bus.out_ready);
`else
    assign out_valid_s = not_empty_s;
    assign write_s     = push_s;
`endif

    // Output select: head of storage, optional bypass, otherwise zeros.
    always_comb begin
        out_word_s = 33'h0_0000_0000;
        out_tag_s  = {TAG_W{1'b0}};
        if (not_empty_s) begin
            out_word_s = {exc_mem_r[rd_ptr_r], data_mem_r[rd_ptr_r]};
            out_tag_s  = tag_mem_r[rd_ptr_r];
        end
`ifdef MULTDIV_RESULT_BYPASS_EN
        else if (bypass_s) begin
            out_word_s = in_reduced_s;
            out_tag_s  = bus.in_tag;
        end
`endif
        else begin
            out_word_s = 33'h0_0000_0000;
            out_tag_s  = {TAG_W{1'b0}};
        end
    end

    // Pointer and occupancy tracking; full/empty come from count alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (read_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({write_s, read_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (write_s) begin
            data_mem_r[wr_ptr_r] <= in_reduced_s[31:0];
            exc_mem_r[wr_ptr_r]  <= in_reduced_s[32];
            tag_mem_r[wr_ptr_r]  <= bus.in_tag;
        end
    end

    assign bus.in_ready      = in_ready_s;
    assign bus.out_valid     = out_valid_s;
    assign bus.out_data      = out_word_s[31:0];
    assign bus.out_exception = out_word_s[32];
    assign bus.out_tag       = out_tag_s;
    assign bus.count         = count_r;
endmodule

// File: tb/tb_multdiv_result_reader.sv
// Self-checking bench for multdiv_result_reader: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_multdiv_result_reader;
    localparam int DEPTH = 2;
    localparam int TAG_W = 5;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0]      data;
        logic             exc;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    entry_t model_q[$];

    always #5 clk = ~clk;

    multdiv_result_reader_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bif ();
    multdiv_result_reader #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clk(clk), .reset(reset), .bus(bif));

    // Reference reduction from signed arithmetic: overflow means the product leaves int32 range.
    function automatic entry_t model_reduce(input logic [63:0] raw, input logic is_div,
                                            input logic dz, input logic [TAG_W-1:0] tag);
        entry_t e;
        longint v;
        v = $signed(raw);
        e.tag = tag;
        if (is_div) begin
            e.exc  = dz;
            e.data = dz ? 32'h0 : raw[31:0];
        end else begin
            e.data = raw[31:0];
            e.exc  = (v > 64'sd2147483647) || (v < -64'sd2147483648);
        end
        return e;
    endfunction

    task automatic set_in(input logic v, input logic [63:0] d, input logic is_div,
                          input logic dz, input logic [TAG_W-1:0] tag);
        bif.in_valid    = v;
        bif.in_data     = d;
        bif.in_is_div   = is_div;
        bif.in_div_zero = dz;
        bif.in_tag      = tag;
    endtask

    // Advance one clock edge and update the model with what the edge should do.
    task automatic tick();
        bit     push, pop, byp;
        entry_t e;
        e   = model_reduce(bif.in_data, bif.in_is_div, bif.in_div_zero, bif.in_tag);
        byp = 1'b0;
`ifdef MULTDIV_RESULT_BYPASS_EN
        byp = (model_q.size() == 0) && bif.in_valid && bif.out_ready;
`endif
        push = bif.in_valid && (model_q.size() < DEPTH) && !byp;
        pop  = (model_q.size() > 0) && bif.out_ready;
        @(posedge clk);
        if (pop) model_q.delete(0);
        if (push) model_q.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        set_in(1'b0, 64'h0, 1'b0, 1'b0, 5'd0);
        bif.out_ready = 1'b0;
        #12;
        n_checks++; if (bif.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", bif.out_valid); end
        n_checks++; if (bif.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", bif.in_ready); end
        n_checks++; if (bif.count !== CNT_W'(0)) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", bif.count); end
        n_checks++; if ({bif.out_data, bif.out_exception, bif.out_tag} !== 38'h0) begin n_errors++; $display("FAIL reset_outputs: got %h/%b/%h expected zeros", bif.out_data, bif.out_exception, bif.out_tag); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_mult();
        set_in(1'b1, 64'h0000_0000_0000_0007, 1'b0, 1'b0, 5'd3);
        bif.out_ready = 1'b1;
        #1;
`ifdef MULTDIV_RESULT_BYPASS_EN
        n_checks++; if (bif.out_valid !== 1'b1 || bif.out_data !== 32'd7) begin n_errors++; $display("FAIL single_bypass: got %b/%h expected 1/7", bif.out_valid, bif.out_data); end
`else
        n_checks++; if (bif.out_valid !== 1'b0) begin n_errors++; $display("FAIL single_no_early: got %b expected 0", bif.out_valid); end
`endif
        tick();
        set_in(1'b0, 64'h0, 1'b0, 1'b0, 5'd0);
        #1;
`ifdef MULTDIV_RESULT_BYPASS_EN
        n_checks++; if (bif.count !== CNT_W'(0)) begin n_errors++; $display("FAIL single_bypass_count: got %0d expected 0", bif.count); end
`else
        n_checks++; if (bif.out_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b expected 1", bif.out_valid); end
        n_checks++; if (bif.out_data !== 32'd7 || bif.out_exception !== 1'b0 || bif.out_tag !== 5'd3) begin n_errors++; $display("FAIL single_entry: got %h/%b/%0d expected 7/0/3", bif.out_data, bif.out_exception, bif.out_tag); end
`endif
        tick();
        n_checks++; if (bif.count !== CNT_W'(0) || bif.out_valid !== 1'b0) begin n_errors++; $display("FAIL single_drain: got count %0d valid %b expected 0/0", bif.count, bif.out_valid); end
    endtask

    task automatic test_reduction();
        logic [63:0] td [8] = '{64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_8000_0000,
                                64'hFFFF_FFFF_8000_0000, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_0000_1234,
                                64'hDEAD_BEEF_0000_1234, 64'h0000_0001_0000_0005};
        logic        tdiv [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        tdz  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ed   [8] = '{32'h0, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'h0, 32'h1234, 32'h5};
        logic        ee   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, td[i], tdiv[i], tdz[i], TAG_W'(i + 10));
            bif.out_ready = 1'b0;
            tick();
            set_in(1'b0, 64'h0, 1'b0, 1'b0, 5'd0);
            #1;
            n_checks++; if (bif.out_data !== ed[i] || bif.out_exception !== ee[i] || bif.out_tag !== TAG_W'(i + 10)) begin n_errors++; $display("FAIL reduce_%0d: got %h/%b/%0d expected %h/%b/%0d", i, bif.out_data, bif.out_exception, bif.out_tag, ed[i], ee[i], i + 10); end
            bif.out_ready = 1'b1;
            tick();
        end
        n_checks++; if (bif.count !== CNT_W'(0)) begin n_errors++; $display("FAIL reduce_drain: got %0d expected 0", bif.count); end
    endtask

    task automatic test_backpressure();
        bif.out_ready = 1'b0;
        set_in(1'b1, 64'h11, 1'b0, 1'b0, 5'd1);
        #1;
        n_checks++; if (bif.in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready0: got %b expected 1", bif.in_ready); end
        tick();
        set_in(1'b1, 64'h22, 1'b0, 1'b0, 5'd2);
        #1;
        n_checks++; if (bif.in_ready !== 1'b1 || bif.count !== CNT_W'(1)) begin n_errors++; $display("FAIL bp_ready1: got %b/%0d expected 1/1", bif.in_ready, bif.count); end
        tick();
        set_in(1'b1, 64'h33, 1'b0, 1'b0, 5'd3);
        #1;
        n_checks++; if (bif.in_ready !== 1'b0 || bif.count !== CNT_W'(2)) begin n_errors++; $display("FAIL bp_full: got ready %b count %0d expected 0/2", bif.in_ready, bif.count); end
        tick();
        n_checks++; if (bif.count !== CNT_W'(2) || bif.out_data !== 32'h11) begin n_errors++; $display("FAIL bp_held: got count %0d data %h expected 2/11", bif.count, bif.out_data); end
        bif.out_ready = 1'b1;
        tick();
        n_checks++; if (bif.count !== CNT_W'(1) || bif.out_data !== 32'h22 || bif.in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_pop1: got count %0d data %h ready %b expected 1/22/1", bif.count, bif.out_data, bif.in_ready); end
        tick();
        n_checks++; if (bif.count !== CNT_W'(1) || bif.out_data !== 32'h33 || bif.out_tag !== 5'd3) begin n_errors++; $display("FAIL bp_third: got count %0d data %h tag %0d expected 1/33/3", bif.count, bif.out_data, bif.out_tag); end
        set_in(1'b0, 64'h0, 1'b0, 1'b0, 5'd0);
        tick();
        n_checks++; if (bif.count !== CNT_W'(0)) begin n_errors++; $display("FAIL bp_drain: got %0d expected 0", bif.count); end
    endtask

    task automatic test_back_to_back();
        bif.out_ready = 1'b0;
        set_in(1'b1, 64'd100, 1'b0, 1'b0, 5'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, 64'(101 + k), 1'b0, 1'b0, TAG_W'(k + 1));
            bif.out_ready = 1'b1;
            #1;
            n_checks++; if (bif.count !== CNT_W'(1) || bif.out_data !== 32'(100 + k) || bif.out_tag !== TAG_W'(k)) begin n_errors++; $display("FAIL b2b_%0d: got count %0d data %0d tag %0d expected 1/%0d/%0d", k, bif.count, bif.out_data, bif.out_tag, 100 + k, k); end
            tick();
        end
        set_in(1'b0, 64'h0, 1'b0, 1'b0, 5'd0);
        #1;
        n_checks++; if (bif.count !== CNT_W'(1) || bif.out_data !== 32'd105) begin n_errors++; $display("FAIL b2b_last: got count %0d data %0d expected 1/105", bif.count, bif.out_data); end
        tick();
        n_checks++; if (bif.count !== CNT_W'(0)) begin n_errors++; $display("FAIL b2b_drain: got %0d expected 0", bif.count); end
    endtask

    task automatic test_reset_mid();
        bif.out_ready = 1'b0;
        set_in(1'b1, 64'hA, 1'b0, 1'b0, 5'd4);
        tick();
        tick();
        set_in(1'b0, 64'h0, 1'b0, 1'b0, 5'd0);
        n_checks++; if (bif.count !== CNT_W'(2)) begin n_errors++; $display("FAIL rmid_fill: got %0d expected 2", bif.count); end
        #2;
        reset = 1'b0;
        #1;
        model_q.delete();
        n_checks++; if (bif.count !== CNT_W'(0) || bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin n_errors++; $display("FAIL rmid_async: got count %0d valid %b ready %b expected 0/0/1", bif.count, bif.out_valid, bif.in_ready); end
        n_checks++; if (bif.out_data !== 32'h0 || bif.out_tag !== 5'd0) begin n_errors++; $display("FAIL rmid_outputs: got %h/%0d expected 0/0", bif.out_data, bif.out_tag); end
        @(negedge clk);
        #2;
        reset = 1'b1;
        set_in(1'b1, 64'h55, 1'b0, 1'b0, 5'd9);
        tick();
        set_in(1'b0, 64'h0, 1'b0, 1'b0, 5'd0);
        n_checks++; if (bif.count !== CNT_W'(1) || bif.out_data !== 32'h55 || bif.out_tag !== 5'd9) begin n_errors++; $display("FAIL rmid_first_push: got count %0d data %h tag %0d expected 1/55/9", bif.count, bif.out_data, bif.out_tag); end
        bif.out_ready = 1'b1;
        tick();
    endtask

`ifdef MULTDIV_RESULT_BYPASS_EN
    task automatic test_bypass();
        bif.out_ready = 1'b1;
        set_in(1'b1, 64'h0000_0000_0000_0042, 1'b0, 1'b0, 5'd7);
        #1;
        n_checks++; if (bif.out_valid !== 1'b1 || bif.out_data !== 32'h42 || bif.out_tag !== 5'd7) begin n_errors++; $display("FAIL bypass_same_cycle: got %b/%h/%0d expected 1/42/7", bif.out_valid, bif.out_data, bif.out_tag); end
        tick();
        set_in(1'b0, 64'h0, 1'b0, 1'b0, 5'd0);
        n_checks++; if (bif.count !== CNT_W'(0)) begin n_errors++; $display("FAIL bypass_count: got %0d expected 0", bif.count); end
    endtask
`endif

    task automatic test_random();
        entry_t      exp;
        logic        exp_valid;
        logic [63:0] d;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0:       d = {$urandom, $urandom};
                1:       d = {32'h0000_0000, $urandom};
                2:       d = {32'hFFFF_FFFF, $urandom};
                default: d = 64'($urandom_range(0, 100));
            endcase
            set_in($urandom_range(0, 2) != 0, d, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, TAG_W'($urandom));
            bif.out_ready = $urandom_range(0, 2) != 0;
            #1;
            exp.data = 32'h0; exp.exc = 1'b0; exp.tag = '0;
            exp_valid = 1'b0;
            if (model_q.size() > 0) begin
                exp_valid = 1'b1;
                exp = model_q[0];
            end
`ifdef MULTDIV_RESULT_BYPASS_EN
            else if (bif.in_valid) begin
                exp_valid = 1'b1;
                exp = model_reduce(bif.in_data, bif.in_is_div, bif.in_div_zero, bif.in_tag);
            end
`endif
            n_checks++; if (bif.out_valid !== exp_valid) begin n_errors++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, bif.out_valid, exp_valid); end
            n_checks++; if (bif.out_data !== exp.data || bif.out_exception !== exp.exc || bif.out_tag !== exp.tag) begin n_errors++; $display("FAIL rnd_entry c=%0d: got %h/%b/%0d expected %h/%b/%0d", c, bif.out_data, bif.out_exception, bif.out_tag, exp.data, exp.exc, exp.tag); end
            n_checks++; if (bif.count !== CNT_W'(model_q.size()) || bif.in_ready !== (model_q.size() < DEPTH)) begin n_errors++; $display("FAIL rnd_count c=%0d: got %0d/%b expected %0d", c, bif.count, bif.in_ready, model_q.size()); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_mult();
        test_reduction();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef MULTDIV_RESULT_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
